// File: rtl/mbox_read_buffer_pkg.sv
// Shared MBOX read-buffer definitions: fill-state encoding, word/quadword
// sizes common with edp and the MBOX, and the memory-word parity helper.
package mbox_read_buffer_pkg;

    localparam int MBOX_WIDTH      = 36;
    localparam int MBOX_QUAD_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } mbox_state_e;

    // Memory words carry odd parity: data plus parity bit has an odd count of ones.
    function automatic logic odd_parity_ok(input logic [MBOX_WIDTH-1:0] data,
                                           input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/mbox_read_buffer_if.sv
// Memory-return and EBOX-read signal bundle for the MBOX quadword read buffer.
// The slave modport is the buffer's view; master is the memory/EBOX side.
interface mbox_read_buffer_if
    import mbox_read_buffer_pkg::*;
#(
    parameter int WORDS = MBOX_QUAD_WORDS,
    parameter int WIDTH = MBOX_WIDTH
);
    localparam int WNW = $clog2(WORDS);

    logic             memStart;
    logic             memWordStrobe;
    logic [WNW-1:0]   memWordNum;
    logic [WIDTH-1:0] memData;
    logic             memPar;
    logic             ebxReadReq;
    logic [WNW-1:0]   ebxWordNum;
    logic [WIDTH-1:0] cacheDataRead;
    logic             mbxDataReady;
    logic             mbxBusy;
    logic             mbxFillDone;
    logic             mbxParErr;

    modport slave (
        input  memStart, memWordStrobe, memWordNum, memData, memPar,
        input  ebxReadReq, ebxWordNum,
        output cacheDataRead, mbxDataReady, mbxBusy, mbxFillDone, mbxParErr
    );

    modport master (
        output memStart, memWordStrobe, memWordNum, memData, memPar,
        output ebxReadReq, ebxWordNum,
        input  cacheDataRead, mbxDataReady, mbxBusy, mbxFillDone, mbxParErr
    );

endinterface

// File: rtl/mbox_read_buffer_ram.sv
// WORDS x WIDTH register file for the MBOX read buffer: one write port, one
// asynchronous read port, and a bypass so a same-cycle write is visible on read.
module mbox_read_buffer_ram #(
    parameter int WORDS = 4,
    parameter int WIDTH = 36
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(WORDS)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [$clog2(WORDS)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data
);

    logic [WIDTH-1:0] mem [WORDS];

    // Contents are deliberately not reset; the owner tracks validity separately.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = mem[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/mbox_read_buffer.sv
// MBOX quadword read buffer feeding EDP cacheDataRead. Optional sticky parity
// checking of returned words is enabled by defining MBOX_PARITY_CHECK_EN.
module mbox_read_buffer
    import mbox_read_buffer_pkg::*;
#(
    parameter int WORDS = MBOX_QUAD_WORDS,
    parameter int WIDTH = MBOX_WIDTH
) (
    input  logic               eboxClk,
    input  logic               eboxReset_n,
    mbox_read_buffer_if.slave  bus
);

    mbox_state_e      state;
    mbox_state_e      state_next;
    logic [WORDS-1:0] valid;
    logic [WORDS-1:0] valid_base;
    logic [WORDS-1:0] valid_next;
    logic             wr_en;
    logic             write_hit;
    logic             read_hit;
    logic             fill_complete;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] data_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    // A start wipes validity before this cycle's strobe or read is considered,
    // so a pending request only ever sees words of the new fill.
    always_comb begin
        wr_en      = bus.memWordStrobe && (bus.memStart || (state == ST_FILL));
        valid_base = bus.memStart ? '0 : valid;
        valid_next = valid_base;
        if (wr_en) begin
            valid_next[bus.memWordNum] = 1'b1;
        end
        write_hit     = wr_en && (bus.memWordNum == bus.ebxWordNum);
        read_hit      = bus.ebxReadReq && (valid_base[bus.ebxWordNum] || write_hit);
        fill_complete = wr_en && (&valid_next);
        state_next    = state;
        if (fill_complete) begin
            state_next = ST_FULL;
        end else if (bus.memStart) begin
            state_next = ST_FILL;
        end
    end

    mbox_read_buffer_ram #(
        .WORDS (WORDS),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (eboxClk),
        .wr_en   (wr_en),
        .wr_addr (bus.memWordNum),
        .wr_data (bus.memData),
        .rd_addr (bus.ebxWordNum),
        .rd_data (rd_data)
    );

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            state   <= ST_IDLE;
            valid   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            valid   <= valid_next;
            busy_q  <= (state_next == ST_FILL);
            done_q  <= fill_complete;
            ready_q <= read_hit;
            if (read_hit) begin
                data_q <= rd_data;
            end
        end
    end

`ifdef MBOX_PARITY_CHECK_EN
    logic par_bad;
    logic par_err_q;

    assign par_bad = wr_en && !odd_parity_ok(MBOX_WIDTH'(bus.memData), bus.memPar);

    // Sticky per fill: a start clears it, but a bad word strobed with the start still counts.
    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            par_err_q <= 1'b0;
        end else if (bus.memStart) begin
            par_err_q <= par_bad;
        end else if (par_bad) begin
            par_err_q <= 1'b1;
        end
    end

    assign bus.mbxParErr = par_err_q;
`else
    assign bus.mbxParErr = 1'b0;
`endif

    assign bus.cacheDataRead = data_q;
    assign bus.mbxDataReady  = ready_q;
    assign bus.mbxBusy       = busy_q;
    assign bus.mbxFillDone   = done_q;

endmodule

// File: tb/tb_mbox_read_buffer.sv
// Directed bench for mbox_read_buffer: a word-level reference model checked every
// cycle, plus literal expectations at key points. Honours MBOX_PARITY_CHECK_EN.
module tb_mbox_read_buffer;
    import mbox_read_buffer_pkg::*;

    localparam int WORDS = 4;
    localparam int WIDTH = 36;
    localparam int WNW   = $clog2(WORDS);
`ifdef MBOX_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic eboxClk     = 1'b0;
    logic eboxReset_n = 1'b1;
    bit   check_en    = 1'b0;
    int   compare_count  = 0;
    int   mismatch_count = 0;

    mbox_read_buffer_if #(.WORDS(WORDS), .WIDTH(WIDTH)) bus ();

    mbox_read_buffer #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
        .eboxClk     (eboxClk),
        .eboxReset_n (eboxReset_n),
        .bus         (bus)
    );

    always #5 eboxClk = ~eboxClk;

    // Reference model: which words of the current fill have arrived, and what
    // every output must be after each edge.
    logic [WIDTH-1:0] m_words [WORDS];
    bit               m_present [WORDS];
    bit               m_filling = 1'b0;
    logic [WIDTH-1:0] e_data  = '0;
    bit               e_ready = 1'b0;
    bit               e_busy  = 1'b0;
    bit               e_done  = 1'b0;
    bit               e_perr  = 1'b0;

    task automatic model_step();
        bit               accept;
        bit               served;
        int               wn;
        int               rn;
        int               n_present;
        logic [WIDTH-1:0] word;
        wn     = int'(bus.memWordNum);
        rn     = int'(bus.ebxWordNum);
        accept = bus.memWordStrobe && (bus.memStart || m_filling);
        if (bus.memStart) begin
            for (int i = 0; i < WORDS; i++) m_present[i] = 1'b0;
            m_filling = 1'b1;
            e_perr    = 1'b0;
        end
        served = bus.ebxReadReq && (m_present[rn] || (accept && wn == rn));
        word   = (accept && wn == rn) ? bus.memData : m_words[rn];
        e_done = 1'b0;
        if (accept) begin
            m_words[wn]   = bus.memData;
            m_present[wn] = 1'b1;
            if (PAR_EN && ($countones({bus.memData, bus.memPar}) % 2 == 0)) e_perr = 1'b1;
            n_present = 0;
            for (int i = 0; i < WORDS; i++) n_present += int'(m_present[i]);
            if (n_present == WORDS) begin
                e_done    = 1'b1;
                m_filling = 1'b0;
            end
        end
        e_busy  = m_filling;
        e_ready = served;
        if (served) e_data = word;
    endtask

    always @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            for (int i = 0; i < WORDS; i++) m_present[i] = 1'b0;
            m_filling = 1'b0;
            e_data    = '0;
            e_ready   = 1'b0;
            e_busy    = 1'b0;
            e_done    = 1'b0;
            e_perr    = 1'b0;
        end else begin
            model_step();
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge eboxClk) begin
        if (check_en) begin
            check_output("model_cacheDataRead", 64'(bus.cacheDataRead), 64'(e_data));
            check_output("model_mbxDataReady",  64'(bus.mbxDataReady),  64'(e_ready));
            check_output("model_mbxBusy",       64'(bus.mbxBusy),       64'(e_busy));
            check_output("model_mbxFillDone",   64'(bus.mbxFillDone),   64'(e_done));
            check_output("model_mbxParErr",     64'(bus.mbxParErr),     64'(e_perr));
        end
    end

    function automatic logic good_par(input logic [WIDTH-1:0] d);
        return ~^d;
    endfunction

    task automatic apply_stimulus(input bit start, input bit stb, input int wn,
                                  input logic [WIDTH-1:0] data, input logic par,
                                  input bit req, input int rn);
        bus.memStart      = start;
        bus.memWordStrobe = stb;
        bus.memWordNum    = WNW'(wn);
        bus.memData       = data;
        bus.memPar        = par;
        bus.ebxReadReq    = req;
        bus.ebxWordNum    = WNW'(rn);
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0);
    endtask

    task automatic strobe(input bit start, input int wn, input logic [WIDTH-1:0] data,
                          input bit req, input int rn);
        apply_stimulus(start, 1'b1, wn, data, good_par(data), req, rn);
    endtask

    task automatic request(input bit start, input int rn);
        apply_stimulus(start, 1'b0, 0, '0, 1'b0, 1'b1, rn);
    endtask

    task automatic step();
        @(posedge eboxClk);
        #1;
    endtask

    logic [WIDTH-1:0] fill_words [WORDS];

    initial begin
        fill_words = '{36'h111111111, 36'h222222222, 36'h333333333, 36'h444444444};
        idle();
        #1 eboxReset_n = 1'b0;
        #1 check_en = 1'b1;
        repeat (2) step();
        check_output("reset_data",  64'(bus.cacheDataRead), 64'h0);
        check_output("reset_ready", 64'(bus.mbxDataReady), 64'h0);
        check_output("reset_busy",  64'(bus.mbxBusy), 64'h0);
        check_output("reset_perr",  64'(bus.mbxParErr), 64'h0);
        eboxReset_n = 1'b1;

        // Full in-order fill
        request(1'b1, 0);
        bus.ebxReadReq = 1'b0;
        step();
        check_output("start_busy", 64'(bus.mbxBusy), 64'h1);
        for (int i = 0; i < WORDS; i++) begin
            strobe(1'b0, i, fill_words[i], 1'b0, 0);
            step();
        end
        check_output("fill_done_pulse", 64'(bus.mbxFillDone), 64'h1);
        check_output("fill_busy_drop",  64'(bus.mbxBusy), 64'h0);
        idle();
        step();
        check_output("fill_done_single", 64'(bus.mbxFillDone), 64'h0);

        // Reads in FULL, single and back-to-back
        request(1'b0, 2);
        step();
        check_output("read2_ready", 64'(bus.mbxDataReady), 64'h1);
        check_output("read2_data",  64'(bus.cacheDataRead), 64'h333333333);
        idle();
        step();
        check_output("read2_pulse_end", 64'(bus.mbxDataReady), 64'h0);
        check_output("read2_hold",      64'(bus.cacheDataRead), 64'h333333333);
        request(1'b0, 0);
        step();
        check_output("b2b_first",  64'(bus.cacheDataRead), 64'h111111111);
        request(1'b0, 3);
        step();
        check_output("b2b_ready",  64'(bus.mbxDataReady), 64'h1);
        check_output("b2b_second", 64'(bus.cacheDataRead), 64'h444444444);

        // Strobe in FULL without start is ignored
        strobe(1'b0, 1, 36'h0DEADBEEF, 1'b0, 0);
        step();
        request(1'b0, 1);
        step();
        check_output("full_strobe_ignored", 64'(bus.cacheDataRead), 64'h222222222);

        // Start with a request pending; word 1 arrives later
        request(1'b1, 1);
        step();
        check_output("start_pending_ready", 64'(bus.mbxDataReady), 64'h0);
        for (int i = 0; i < 5; i++) begin
            request(1'b0, 1);
            step();
            check_output("pending_no_ready", 64'(bus.mbxDataReady), 64'h0);
        end
        strobe(1'b0, 1, 36'h987654321, 1'b1, 1);
        step();
        check_output("pending_served_ready", 64'(bus.mbxDataReady), 64'h1);
        check_output("pending_served_data",  64'(bus.cacheDataRead), 64'h987654321);
        idle();
        step();
        check_output("pending_pulse_end", 64'(bus.mbxDataReady), 64'h0);

        // Same-cycle strobe and request of word 0
        strobe(1'b0, 0, 36'h123456789, 1'b1, 0);
        step();
        check_output("bypass_ready", 64'(bus.mbxDataReady), 64'h1);
        check_output("bypass_data",  64'(bus.cacheDataRead), 64'h123456789);
        strobe(1'b0, 3, 36'h055555555, 1'b0, 0);
        step();
        strobe(1'b0, 2, 36'h0AAAAAAAA, 1'b0, 0);
        step();
        check_output("ooo_fill_done", 64'(bus.mbxFillDone), 64'h1);

        // Start with strobe: old fill's words no longer deliverable
        strobe(1'b1, 3, 36'hABCDEF012, 1'b1, 0);
        step();
        check_output("start_strobe_busy",  64'(bus.mbxBusy), 64'h1);
        check_output("start_strobe_stale", 64'(bus.mbxDataReady), 64'h0);
        request(1'b0, 0);
        repeat (2) step();
        check_output("stale_word_blocked", 64'(bus.mbxDataReady), 64'h0);
        request(1'b0, 3);
        step();
        check_output("start_strobe_data", 64'(bus.cacheDataRead), 64'hABCDEF012);

        // Reset mid-fill, then requests in IDLE
        strobe(1'b0, 0, 36'h0CAFE0000, 1'b0, 0);
        step();
        idle();
        eboxReset_n = 1'b0;
        #1;
        check_output("midreset_busy", 64'(bus.mbxBusy), 64'h0);
        step();
        check_output("midreset_no_done", 64'(bus.mbxFillDone), 64'h0);
        eboxReset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            request(1'b0, i);
            step();
            check_output("idle_no_ready", 64'(bus.mbxDataReady), 64'h0);
        end

        // Bad parity on an accepted word
        request(1'b1, 0);
        bus.ebxReadReq = 1'b0;
        step();
        apply_stimulus(1'b0, 1'b1, 1, 36'h000000003, 1'b0, 1'b0, 0);
        step();
        check_output("parity_set", 64'(bus.mbxParErr), 64'(PAR_EN));
        request(1'b0, 1);
        step();
        check_output("parity_sticky",     64'(bus.mbxParErr), 64'(PAR_EN));
        check_output("parity_word_kept",  64'(bus.cacheDataRead), 64'h000000003);
        request(1'b1, 0);
        bus.ebxReadReq = 1'b0;
        step();
        check_output("parity_cleared", 64'(bus.mbxParErr), 64'h0);
        idle();
        step();

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
